seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the 7-segment drive path: monitors a multiplexed,

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/seg_scan_decoder.sv | 139 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns, digit count and scan FSM encoding
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low 7-bit patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - active-low 7-segment pattern to hex nibble decoder
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       known,
  output logic [3:0] nibble
);

  always_comb begin
    known  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: known  = 1'b0;
      default:   known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - reads back a multiplexed active-low 6-digit segment bus
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   seg_sel,
  input  logic [7:0]              seg_data,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    err,
  output logic                    frame_done
);

  logic [13:0] s1, s2, s3;
  logic [5:0]  sel_inv;
  logic        sel_ok;
  logic        changed;
  logic [2:0]  idx;
  logic [5:0]  idx_bit;
  logic        known;
  logic [3:0]  nibble;
  logic        commit;
  logic [5:0]  seen;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Idle bus value on reset so a held pin pattern is seen as a fresh change
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 14'h3FFF;
      s2 <= 14'h3FFF;
      s3 <= 14'h3FFF;
    end else begin
      s1 <= {seg_sel, seg_data};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sel_inv = ~s2[13:8];
  assign sel_ok  = (sel_inv != 6'd0) && ((sel_inv & (sel_inv - 6'd1)) == 6'd0);
  assign changed = (s2 != s3);

  // Commit writes from s3: it is the sample that was proven stable
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s3[8+i]) idx = 3'(i);
    end
  end

  assign idx_bit = 6'd1 << idx;

  seg7_to_hex u_dec (
    .pattern (s3[6:0]),
    .known   (known),
    .nibble  (nibble)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(STABLE_CYCLES - 1)) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
        end else if (changed) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits     <= '0;
      dp         <= '0;
      valid      <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      seen       <= '0;
    end else begin
      err        <= 1'b0;
      frame_done <= 1'b0;
      if (commit) begin
        dp[idx]    <= ~s3[7];
        valid[idx] <= known;
        if (known) digits[{idx, 2'b00} +: 4] <= nibble;
        else       err <= 1'b1;
        if ((seen | idx_bit) == 6'h3F) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen | idx_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed table-driven bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic [5:0]  valid;
  logic        err;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data),
    .digits     (digits),
    .dp         (dp),
    .valid      (valid),
    .err        (err),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (err)        err_cnt++;
    if (frame_done) fd_cnt++;
  end

  typedef struct {
    logic [5:0]  sel;
    logic [7:0]  data;
    int          cycles;
    logic [23:0] exp_digits;
    logic [5:0]  exp_valid;
    logic [5:0]  exp_dp;
    int          exp_errs;
    int          exp_fds;
  } vec_t;

  vec_t tbl [6];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [23:0] d, input logic [5:0] v,
                           input logic [5:0] p, input int e, input int f);
    chk({tag, " digits"}, 32'(digits), 32'(d));
    chk({tag, " valid"}, 32'(valid), 32'(v));
    chk({tag, " dp"}, 32'(dp), 32'(p));
    chk({tag, " err pulses"}, err_cnt, e);
    chk({tag, " frame pulses"}, fd_cnt, f);
  endtask

  logic [7:0] pats [6];
  logic [5:0] sel_v;

  initial begin
    pats = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    tbl[0] = '{6'h3B, 8'h7F, 8, 24'h654321, 6'h3B, 6'h04, 1, 1};
    tbl[1] = '{6'h3C, 8'hC0, 10, 24'h654321, 6'h3B, 6'h04, 1, 1};
    tbl[2] = '{6'h3F, 8'hC0, 10, 24'h654321, 6'h3B, 6'h04, 1, 1};
    tbl[3] = '{6'h37, 8'h08, 8, 24'h65A321, 6'h3B, 6'h0C, 1, 1};
    tbl[4] = '{6'h3E, 8'h40, 8, 24'h65A320, 6'h3B, 6'h0D, 1, 1};
    tbl[5] = '{6'h3F, 8'hFF, 4, 24'h65A320, 6'h3B, 6'h0D, 1, 1};

    rst = 1'b1;
    seg_sel = 6'h3F;
    seg_data = 8'hFF;
    step(3);
    chk_state("reset", 24'h0, 6'h0, 6'h0, 0, 0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // single stable digit: commit lands exactly on the 7th edge
    seg_sel = 6'h3E;
    seg_data = 8'hC0;
    step(6);
    chk("t1 valid before commit", 32'(valid), 32'h00);
    step(1);
    chk("t1 valid at commit", 32'(valid), 32'h01);
    step(3);
    chk_state("t1", 24'h0, 6'h01, 6'h00, 0, 0);

    // full scan, 6 cycles per digit
    for (int i = 0; i < 6; i++) begin
      sel_v = 6'h3F & ~(6'd1 << i);
      seg_sel = sel_v;
      seg_data = pats[i];
      step(6);
    end
    chk("t2 frame_done before last commit", 32'(frame_done), 32'd0);
    step(1);
    chk("t2 frame_done on last commit", 32'(frame_done), 32'd1);
    step(1);
    chk("t2 frame_done cleared", 32'(frame_done), 32'd0);
    chk_state("t2", 24'h654321, 6'h3F, 6'h00, 0, 1);

    for (int v = 0; v < 3; v++) begin
      seg_sel = tbl[v].sel;
      seg_data = tbl[v].data;
      step(tbl[v].cycles);
      chk_state($sformatf("vec%0d", v), tbl[v].exp_digits, tbl[v].exp_valid,
                tbl[v].exp_dp, tbl[v].exp_errs, tbl[v].exp_fds);
      if (v == 0) begin
        // glitching data never stays stable long enough to commit
        seg_sel = 6'h3E;
        for (int k = 0; k < 10; k++) begin
          seg_data = k[0] ? 8'hA4 : 8'hC0;
          step(2);
        end
        chk_state("glitch", 24'h654321, 6'h3B, 6'h04, 1, 1);
      end
    end

    for (int v = 3; v < 6; v++) begin
      seg_sel = tbl[v].sel;
      seg_data = tbl[v].data;
      step(tbl[v].cycles);
      chk_state($sformatf("vec%0d", v), tbl[v].exp_digits, tbl[v].exp_valid,
                tbl[v].exp_dp, tbl[v].exp_errs, tbl[v].exp_fds);
    end

    // reset lands on the would-be commit edge
    seg_sel = 6'h3D;
    seg_data = 8'h99;
    step(6);
    rst = 1'b1;
    step(1);
    chk_state("t6 reset", 24'h0, 6'h00, 6'h00, 1, 1);
    chk("t6 err", 32'(err), 32'd0);
    rst = 1'b0;
    step(6);
    chk("t6 valid restart early", 32'(valid), 32'h00);
    step(1);
    chk("t6 valid restart commit", 32'(valid), 32'h02);
    chk("t6 digits restart commit", 32'(digits), 32'h000040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
